// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared constants, md FSM states and the Tnew/Tuse hazard check
package hazard_ctrl_pkg;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
  function automatic logic data_hz(input logic [4:0] r, input logic [1:0] tuse, input logic [4:0] e_a3, input logic [1:0] e_tnew, input logic [4:0] m_a3, input logic [1:0] m_tnew);
    return r != 5'd0 && tuse != TUSE_NONE && ((e_a3 == r && e_tnew > tuse) || (m_a3 == r && m_tnew > tuse));
  endfunction
endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// hazard_ctrl_md_busy_timer: mult/div busy counter; start/div in, md_busy/md_done out
module hazard_ctrl_md_busy_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic md_busy,
  output logic md_done
);
  md_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    cnt_n = state == MD_IDLE ? (start ? (div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) : '0) : cnt - CNT_W'(1);
    state_n = cnt_n != '0 ? MD_BUSY : MD_IDLE;
  end
  always_comb begin
    md_busy = state == MD_BUSY;
    md_done = state == MD_BUSY && cnt == CNT_W'(1);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush scheduler with md sequencing; HAZARD_STALL_CNT_EN adds stall_cnt/md_stall_cnt
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] E_A3,
  input  logic [1:0] E_Tnew,
  input  logic [4:0] M_A3,
  input  logic [1:0] M_Tnew,
  input  logic D_is_md,
  input  logic E_md_start,
  input  logic E_md_div,
  output logic stall,
  output logic F_WE,
  output logic D_WE,
  output logic E_Flush,
  output logic M_Flush,
  output logic W_WE,
`ifdef HAZARD_STALL_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt,
`endif
  output logic md_busy,
  output logic md_done
);
  logic rs_hz, rt_hz, md_hz;
  hazard_ctrl_md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .start(E_md_start),
    .div(E_md_div),
    .md_busy(md_busy),
    .md_done(md_done)
  );
  always_comb begin
    rs_hz = data_hz(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
    rt_hz = data_hz(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
    md_hz = D_is_md && (md_busy || E_md_start);
    stall = rs_hz || rt_hz || md_hz;
    F_WE = !stall;
    D_WE = !stall;
    E_Flush = stall;
    M_Flush = 1'b0;
    W_WE = 1'b1;
  end
`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
      if (md_hz && !rs_hz && !rt_hz && !(&md_stall_cnt)) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table plus md sequences checked through an expected-value queue
module tb_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] D_rs = '0, D_rt = '0, E_A3 = '0, M_A3 = '0;
  logic [1:0] D_Tuse_rs = 2'd3, D_Tuse_rt = 2'd3, E_Tnew = '0, M_Tnew = '0;
  logic D_is_md = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
  logic stall, F_WE, D_WE, E_Flush, M_Flush, W_WE, md_busy, md_done;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif
  int checks = 0, failures = 0;
  typedef struct {logic s; logic b; logic d;} exp_t;
  typedef struct {logic [4:0] rs; logic [4:0] rt; logic [1:0] tu_rs; logic [1:0] tu_rt; logic [4:0] e_a3; logic [1:0] e_tnew; logic [4:0] m_a3; logic [1:0] m_tnew; logic is_md; logic s;} vec_t;
  exp_t q[$];
  vec_t tbl[12];
  hazard_ctrl dut (
    .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew), .D_is_md(D_is_md),
    .E_md_start(E_md_start), .E_md_div(E_md_div), .stall(stall), .F_WE(F_WE), .D_WE(D_WE),
    .E_Flush(E_Flush), .M_Flush(M_Flush), .W_WE(W_WE),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt),
`endif
    .md_busy(md_busy), .md_done(md_done)
  );
  always #5 clk = ~clk;
  task automatic step(input string nm, input logic s, input logic b, input logic d);
    exp_t e;
    logic [7:0] act, req;
    q.push_back('{s, b, d});
    @(negedge clk);
    e = q.pop_front();
    act = {stall, F_WE, D_WE, E_Flush, M_Flush, W_WE, md_busy, md_done};
    req = {e.s, ~e.s, ~e.s, e.s, 1'b0, 1'b1, e.b, e.d};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got {stall,F_WE,D_WE,E_Flush,M_Flush,W_WE,busy,done}=%b want %b", nm, act, req);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic clear_d();
    D_rs = '0; D_rt = '0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
    E_A3 = '0; E_Tnew = '0; M_A3 = '0; M_Tnew = '0;
  endtask
  initial begin
    tbl[0]  = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b1};
    tbl[1]  = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{5'd0, 5'd0, 2'd3, 2'd0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{5'd7, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0, 1'b1};
    tbl[4]  = '{5'd7, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0, 1'b0};
    tbl[5]  = '{5'd0, 5'd9, 2'd3, 2'd1, 5'd9, 2'd2, 5'd0, 2'd0, 1'b0, 1'b1};
    tbl[6]  = '{5'd4, 5'd0, 2'd3, 2'd3, 5'd4, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{5'd4, 5'd0, 2'd2, 2'd3, 5'd4, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0};
    tbl[9]  = '{5'd3, 5'd0, 2'd0, 2'd3, 5'd4, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0};
    tbl[10] = '{5'd0, 5'd31, 2'd3, 2'd0, 5'd0, 2'd0, 5'd31, 2'd2, 1'b0, 1'b1};
    tbl[11] = '{5'd3, 5'd8, 2'd0, 2'd0, 5'd3, 2'd1, 5'd8, 2'd1, 1'b0, 1'b1};
    @(posedge clk);
    #1;
    step("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      D_rs = tbl[i].rs; D_rt = tbl[i].rt; D_Tuse_rs = tbl[i].tu_rs; D_Tuse_rt = tbl[i].tu_rt;
      E_A3 = tbl[i].e_a3; E_Tnew = tbl[i].e_tnew; M_A3 = tbl[i].m_a3; M_Tnew = tbl[i].m_tnew;
      D_is_md = tbl[i].is_md;
      step($sformatf("vec%0d", i), tbl[i].s, 1'b0, 1'b0);
    end
    clear_d();
    D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b1;
    step("div_start", 1'b1, 1'b0, 1'b0);
    E_md_start = 1'b0; E_md_div = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin D_rs = 5'd5; D_Tuse_rs = 2'd0; E_A3 = 5'd5; E_Tnew = 2'd1; end
      else clear_d();
      step($sformatf("div_busy%0d", c), 1'b1, 1'b1, c == 10);
    end
    step("div_after", 1'b0, 1'b0, 1'b0);
    E_md_start = 1'b1;
    step("mult_start", 1'b1, 1'b0, 1'b0);
    E_md_start = 1'b0;
    step("mult_busy1", 1'b1, 1'b1, 1'b0);
    step("mult_busy2", 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    step("mult_busy3_rst", 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    step("mult_after_rst", 1'b0, 1'b0, 1'b0);
    D_is_md = 1'b0; E_md_start = 1'b1;
    step("restart_start", 1'b0, 1'b0, 1'b0);
    E_md_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      E_md_start = c == 2;
      step($sformatf("restart_busy%0d", c), 1'b0, 1'b1, c == 5);
    end
    E_md_start = 1'b0;
    step("restart_after", 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
